alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational alu (in_a, in_b, op_code -> out) between two requesters.
- Requester 0 is the core execute path; requester 1 is an auxiliary unit (address generation / CSR update).
- Grants one operation per cycle and drives the alu operands.
- Registers the result and returns it to the owning requester over a valid/ready response channel, with full back-to-back throughput.

Parameters:
- WIDTH, 32, operand/result width; must match the alu data width.
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- req0_op  in  4  requester 0 alu op code (ADD, SUB, SLL, SLT, XOR, SRL, ...).
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions and widths as requester 0, for requester 1.
- resp0_valid  out  1  result pending for requester 0.
- resp0_ready  in  1  requester 0 takes the result.
- resp1_valid  out  1  result pending for requester 1.
- resp1_ready  in  1  requester 1 takes the result.
- resp_data  out  WIDTH  registered result, shared by both response channels.
- alu_in_a  out  WIDTH  to alu in_a.
- alu_in_b  out  WIDTH  to alu in_b.
- alu_op_code  out  4  to alu op_code.
- alu_out  in  WIDTH  from alu out.

Behaviour:
- Reset (asynchronous, immediate on reset_n low):
  - res_valid=0, owner=0, resp_data=0, last_grant=1 (so requester 0 wins the first tie).
  - All resp*_valid=0 and all req*_ready=0 while reset_n is low.
- State is held by res_valid: EMPTY (0) or FULL (1).
- can_accept = !res_valid || (resp_valid of owner && matching resp_ready).
- Grant (combinational), only when can_accept:
  - Only one valid requester: that requester wins.
  - Both valid, FIXED_PRIO=1: requester 0 wins.
  - Both valid, FIXED_PRIO=0: the requester != last_grant wins.
  - reqN_ready = grant to N; at most one ready high per cycle.
  - reqN_ready never depends on reqN_ready; it may depend on reqN_valid.
- Alu drive (combinational): while a grant is active, alu_in_a/alu_in_b/alu_op_code = the granted requester's fields. With no grant, drive 0, 0, 4'b0000 (ADD).
- On the clock edge with an accept:
  - resp_data <= alu_out, owner <= granted id, last_grant <= granted id, res_valid <= 1.
  - Latency: result visible the cycle after acceptance.
- On the clock edge with response handshake and no new accept: res_valid <= 0; resp_data holds its last value.
- Simultaneous response handshake and new accept in one cycle: the new result replaces the old one; res_valid stays 1; owner may change.
- resp0_valid = res_valid && owner==0; resp1_valid = res_valid && owner==1.
- resp_ready of the non-owner is ignored.
- Backpressure:
  - While FULL and the owner's resp_ready=0: no grants; resp_data, owner and resp valids stable.
  - Requesters must hold their req fields stable while valid and not ready. The arbiter does not check this.
- last_grant updates only on an accept; idle cycles do not rotate priority.
- Reset asserted mid-operation: the pending result is discarded and no response is issued after release. Requesters re-present their operations.
- All alu arithmetic is the alu's; the arbiter does no width conversion. Operands pass through bit-exact.

Test Plan:
- Single request: req0 ADD a=1, b=1, resp0_ready=1 -> req0_ready=1 in cycle 0; resp0_valid=1 and resp_data=2 in cycle 1; resp1_valid stays 0.
- Tie after reset, round-robin: req0 SLL a=3, b=2 and req1 SUB a=5, b=3 both held valid, both resp_ready=1 -> requester 0 granted first, resp_data=12 on resp0. Next cycle requester 1 granted, resp_data=2 on resp1. Grants then alternate while both stay valid.
- FIXED_PRIO=1, same stimulus with req0 re-presenting every cycle -> req1_ready never asserts; resp0 returns 12 every cycle.
- Backpressure: req1 XOR a=0, b=32'hFFFFFFFF with resp1_ready=0 for 3 cycles -> resp1_valid=1 and resp_data=32'hFFFFFFFF stable; req0_ready=0 despite req0_valid. On the cycle resp1_ready=1, req0 is accepted and its result appears the next cycle.
- Back-to-back: req0 issues SLT -1<0, then SRL 32'h80000000>>31 on consecutive cycles with resp0_ready=1 -> resp_data=1 on two consecutive cycles, with no bubble.
- Reset mid-op: accept req0 ADD 1+0, then pull reset_n low before resp0_ready -> resp0_valid drops immediately. After release, outputs are at reset values and no stale response is issued.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between two requesters.
// It grants one operation per cycle, registers the alu result, and returns
// that result to the owning requester over a valid/ready response channel.
module alu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  output logic [3:0]       alu_op_code,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } res_state_t;

  res_state_t       state_q, state_d;
  logic             owner_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] resp_data_q;

  logic owner_hs;
  logic can_accept;
  logic grant0;
  logic grant1;
  logic accept;

  // Result-slot occupancy register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant decision and next slot state. A slot being drained this cycle can
  // be refilled in the same cycle, which gives back-to-back throughput.
  // Readies are gated by reset_n because the slot reads EMPTY during reset.
  always_comb begin
    owner_hs   = (state_q == FULL) && (owner_q ? resp1_ready : resp0_ready);
    can_accept = reset_n && ((state_q == EMPTY) || owner_hs);
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (can_accept) begin
      if (req0_valid && req1_valid) begin
        if (FIXED_PRIO || last_grant_q) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    accept  = grant0 | grant1;
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if (owner_hs) begin
      state_d = EMPTY;
    end
  end

  // Result, owner and round-robin pointer; all change only on an accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_data_q  <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      resp_data_q  <= alu_out;
      owner_q      <= grant1;
      last_grant_q <= grant1;
    end
  end

  // Steer the granted requester's operands to the alu; ADD of zeros when idle.
  always_comb begin
    alu_in_a    = '0;
    alu_in_b    = '0;
    alu_op_code = 4'b0000;
    if (grant0) begin
      alu_in_a    = req0_a;
      alu_in_b    = req0_b;
      alu_op_code = req0_op;
    end else if (grant1) begin
      alu_in_a    = req1_a;
      alu_in_b    = req1_b;
      alu_op_code = req1_op;
    end
  end

  // Handshake outputs.
  always_comb begin
    req0_ready  = grant0;
    req1_ready  = grant1;
    resp0_valid = (state_q == FULL) && !owner_q;
    resp1_valid = (state_q == FULL) && owner_q;
    resp_data   = resp_data_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized checks of alu_arbiter. A
// round-robin and a fixed-priority instance see the same stimulus, and each
// one is compared against its own transaction-level reference model.
module tb_alu_arbiter;

  localparam int unsigned W = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]   req0_op = '0, req1_op = '0;

  logic [1:0]        r0_rdy, r1_rdy, p0_v, p1_v;
  logic [1:0][W-1:0] rdata, ain, bin, aout;
  logic [1:0][3:0]   aop;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state per instance (index 0 round-robin, 1 fixed).
  bit           m_full[2];
  bit           m_owner[2];
  logic [W-1:0] m_data[2];
  bit           m_last[2];
  int           e_grant[2];

  always #5 clock = ~clock;

  function automatic logic [W-1:0] alu_f(input logic [3:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << b[4:0];
      4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a >> b[4:0];
      4'd6:    return a | b;
      4'd7:    return a & b;
      default: return '0;
    endcase
  endfunction

  assign aout[0] = alu_f(aop[0], ain[0], bin[0]);
  assign aout[1] = alu_f(aop[1], ain[1], bin[1]);

  alu_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b0)) dut_rr (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(r0_rdy[0]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(r1_rdy[0]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(p0_v[0]), .resp0_ready(resp0_ready), .resp1_valid(p1_v[0]), .resp1_ready(resp1_ready),
    .resp_data(rdata[0]), .alu_in_a(ain[0]), .alu_in_b(bin[0]), .alu_op_code(aop[0]), .alu_out(aout[0])
  );

  alu_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b1)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(r0_rdy[1]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(r1_rdy[1]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(p0_v[1]), .resp0_ready(resp0_ready), .resp1_valid(p1_v[1]), .resp1_ready(resp1_ready),
    .resp_data(rdata[1]), .alu_in_a(ain[1]), .alu_in_b(bin[1]), .alu_op_code(aop[1]), .alu_out(aout[1])
  );

  task automatic chk(input string tag, input int inst, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i]  = 1'b0;
      m_owner[i] = 1'b0;
      m_data[i]  = '0;
      m_last[i]  = 1'b1;
      e_grant[i] = -1;
    end
  endtask

  // Decide who the model expects to win this cycle, then compare every output.
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit can;
      int g;
      logic [W-1:0] ea, eb;
      logic [3:0] eop;
      can = !m_full[i] || (m_owner[i] ? resp1_ready : resp0_ready);
      g = -1;
      if (can) begin
        if (req0_valid && req1_valid) g = (i == 1) ? 0 : (m_last[i] ? 0 : 1);
        else if (req0_valid) g = 0;
        else if (req1_valid) g = 1;
      end
      e_grant[i] = g;
      ea = '0; eb = '0; eop = 4'd0;
      if (g == 0) begin ea = req0_a; eb = req0_b; eop = req0_op; end
      if (g == 1) begin ea = req1_a; eb = req1_b; eop = req1_op; end
      chk("req0_ready", i, W'(r0_rdy[i]), W'(g == 0));
      chk("req1_ready", i, W'(r1_rdy[i]), W'(g == 1));
      chk("alu_in_a", i, ain[i], ea);
      chk("alu_in_b", i, bin[i], eb);
      chk("alu_op_code", i, W'(aop[i]), W'(eop));
      chk("resp0_valid", i, W'(p0_v[i]), W'(m_full[i] && !m_owner[i]));
      chk("resp1_valid", i, W'(p1_v[i]), W'(m_full[i] && m_owner[i]));
      chk("resp_data", i, rdata[i], m_data[i]);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (e_grant[i] == 0) begin
        m_data[i] = alu_f(req0_op, req0_a, req0_b);
        m_owner[i] = 1'b0; m_last[i] = 1'b0; m_full[i] = 1'b1;
      end else if (e_grant[i] == 1) begin
        m_data[i] = alu_f(req1_op, req1_a, req1_b);
        m_owner[i] = 1'b1; m_last[i] = 1'b1; m_full[i] = 1'b1;
      end else if (m_full[i] && (m_owner[i] ? resp1_ready : resp0_ready)) begin
        m_full[i] = 1'b0;
      end
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising
  // edge, and hand control back 1 time unit after it.
  task automatic cycle();
    @(negedge clock);
    check_all();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req0_ready", i, W'(r0_rdy[i]), '0);
      chk("rst_req1_ready", i, W'(r1_rdy[i]), '0);
      chk("rst_resp0_valid", i, W'(p0_v[i]), '0);
      chk("rst_resp1_valid", i, W'(p1_v[i]), '0);
      chk("rst_resp_data", i, rdata[i], '0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit keep0, keep1;

    #3;
    do_reset();

    // Single request on requester 0.
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    cycle();
    req0_valid = 1'b0;
    chk("single_data", 0, rdata[0], 32'd2);
    chk("single_resp0", 0, W'(p0_v[0]), 32'd1);
    chk("single_resp1", 0, W'(p1_v[0]), 32'd0);
    cycle();

    // Tie straight after reset.
    do_reset();
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd3; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd5; req1_b = 32'd3;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    cycle();
    chk("tie_first_data", 0, rdata[0], 32'd12);
    chk("tie_first_resp0", 0, W'(p0_v[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_data", 0, rdata[0], (k % 2 == 0) ? 32'd2 : 32'd12);
      chk("rr_resp1", 0, W'(p1_v[0]), W'(k % 2 == 0));
      chk("fp_data", 1, rdata[1], 32'd12);
      chk("fp_resp0", 1, W'(p0_v[1]), 32'd1);
      chk("fp_req1_ready", 1, W'(r1_rdy[1]), 32'd0);
    end

    // Backpressure on requester 1's response.
    do_reset();
    req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'd0; req1_b = 32'hFFFF_FFFF;
    resp1_ready = 1'b0; resp0_ready = 1'b1;
    cycle();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd7; req0_b = 32'd8;
    for (int k = 0; k < 3; k++) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        chk("bp_resp1", i, W'(p1_v[i]), 32'd1);
        chk("bp_data", i, rdata[i], 32'hFFFF_FFFF);
        chk("bp_req0_ready", i, W'(r0_rdy[i]), 32'd0);
      end
    end
    resp1_ready = 1'b1;
    cycle();
    req0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_after_data", i, rdata[i], 32'd15);
      chk("bp_after_resp0", i, W'(p0_v[i]), 32'd1);
      chk("bp_after_resp1", i, W'(p1_v[i]), 32'd0);
    end
    cycle();

    // Back-to-back issue from requester 0.
    resp0_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'hFFFF_FFFF; req0_b = 32'd0;
    cycle();
    req0_op = 4'd5; req0_a = 32'h8000_0000; req0_b = 32'd31;
    chk("b2b_first", 0, rdata[0], 32'd1);
    chk("b2b_first_v", 0, W'(p0_v[0]), 32'd1);
    cycle();
    req0_valid = 1'b0;
    chk("b2b_second", 0, rdata[0], 32'd1);
    chk("b2b_second_v", 0, W'(p0_v[0]), 32'd1);
    cycle();

    // Reset while a result is pending.
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd0;
    cycle();
    chk("midrst_pending", 0, W'(p0_v[0]), 32'd1);
    do_reset();
    resp0_ready = 1'b1;
    cycle();
    chk("midrst_no_stale", 0, W'(p0_v[0]), 32'd0);
    chk("midrst_data", 0, rdata[0], 32'd0);

    // Randomized traffic; a requester holds its fields while waiting on the
    // round-robin instance.
    for (int n = 0; n < 400; n++) begin
      keep0 = req0_valid && (e_grant[0] != 0);
      keep1 = req1_valid && (e_grant[0] != 1);
      if (!keep0) begin
        req0_valid = ($urandom_range(0, 9) < 7);
        req0_op = 4'($urandom_range(0, 7));
        req0_a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
        req0_b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      end
      if (!keep1) begin
        req1_valid = ($urandom_range(0, 9) < 7);
        req1_op = 4'($urandom_range(0, 7));
        req1_a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
        req1_b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      end
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
